gene_net_attr: RTL and testbench

GENE_NET_ATTR -- requirements
Module: gene_net_attr

---
 rtl/gene_net_attr_if.sv | 36 +++
 rtl/gene_net_attr.sv | 166 ++++++++++++++++
 tb/tb_gene_net_attr.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/gene_net_attr_if.sv
// Bundles the rule-programming, run-control and result signals of the gene
// network attractor engine. Clock and reset stay as plain module ports.
interface gene_net_attr_if #(
  parameter int N  = 8,
  parameter int SW = 16
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  logic          cfg_we;
  logic [GW-1:0] cfg_gene;
  logic          cfg_term;
  logic [N-1:0]  cfg_pos;
  logic [N-1:0]  cfg_neg;
  logic          start;
  logic [N-1:0]  x_in;
  logic [SW-1:0] max_steps;
  logic          abort;
  logic [N-1:0]  x_out;
  logic          busy;
  logic          done;
  logic [1:0]    status;
  logic [SW-1:0] period;
  logic [SW-1:0] steps;

  modport master (
    output cfg_we, cfg_gene, cfg_term, cfg_pos, cfg_neg,
    output start, x_in, max_steps, abort,
    input  x_out, busy, done, status, period, steps
  );

  modport slave (
    input  cfg_we, cfg_gene, cfg_term, cfg_pos, cfg_neg,
    input  start, x_in, max_steps, abort,
    output x_out, busy, done, status, period, steps
  );
endinterface

// File: rtl/gene_net_attr.sv
// Synchronous Boolean gene network with two programmable product terms per gene;
// iterates from a loaded state and finds the attractor using Brent's algorithm.
module gene_net_attr #(
  parameter int N  = 8,
  parameter int SW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  gene_net_attr_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_FIXED   = 2'b01;
  localparam logic [1:0] ST_CYCLE   = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  state_t        state_q, state_d;
  logic [N-1:0]  pos_q [N][2];
  logic [N-1:0]  pos_d [N][2];
  logic [N-1:0]  neg_q [N][2];
  logic [N-1:0]  neg_d [N][2];
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  saved_q, saved_d;
  logic [SW-1:0] power_q, power_d;
  logic          power_sat_q, power_sat_d;
  logic [SW-1:0] lam_q, lam_d;
  logic [SW-1:0] steps_q, steps_d;
  logic [SW-1:0] max_q, max_d;
  logic [SW-1:0] period_q, period_d;
  logic [1:0]    status_q, status_d;
  logic          done_q, done_d;

  logic [N-1:0][1:0] term_hit;
  logic [N-1:0]      x_next;
  logic [SW-1:0]     lam_inc;
  logic [SW-1:0]     steps_inc;

  // A term with no literals selected is disabled rather than trivially true.
  for (genvar gi = 0; gi < N; gi++) begin : g_gene
    for (genvar ti = 0; ti < 2; ti++) begin : g_term
      assign term_hit[gi][ti] = (|(pos_q[gi][ti] | neg_q[gi][ti]))
                             && ((x_q & pos_q[gi][ti]) == pos_q[gi][ti])
                             && ((x_q & neg_q[gi][ti]) == '0);
    end
    assign x_next[gi] = |term_hit[gi];
  end

  assign lam_inc   = (&lam_q)   ? lam_q   : lam_q   + SW'(1);
  assign steps_inc = (&steps_q) ? steps_q : steps_q + SW'(1);

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    neg_d       = neg_q;
    x_d         = x_q;
    saved_d     = saved_q;
    power_d     = power_q;
    power_sat_d = power_sat_q;
    lam_d       = lam_q;
    steps_d     = steps_q;
    max_d       = max_q;
    period_d    = period_q;
    status_d    = status_q;
    done_d      = 1'b0;

    if (bus.cfg_we && (state_q != RUN) && (32'(bus.cfg_gene) < N)) begin
      pos_d[bus.cfg_gene][bus.cfg_term] = bus.cfg_pos;
      neg_d[bus.cfg_gene][bus.cfg_term] = bus.cfg_neg;
    end

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = RUN;
          x_d         = bus.x_in;
          saved_d     = bus.x_in;
          power_d     = SW'(1);
          power_sat_d = 1'b0;
          lam_d       = '0;
          steps_d     = '0;
          max_d       = bus.max_steps;
          status_d    = ST_NONE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d  = IDLE;
          status_d = ST_NONE;
        end else if (max_q == '0) begin
          state_d  = DONE;
          status_d = ST_TIMEOUT;
          period_d = '0;
          done_d   = 1'b1;
        end else begin
          x_d     = x_next;
          steps_d = steps_inc;
          if (x_next == saved_q) begin
            state_d  = DONE;
            period_d = lam_inc;
            status_d = (lam_inc == SW'(1)) ? ST_FIXED : ST_CYCLE;
            done_d   = 1'b1;
          end else begin
            // Once power can no longer double, the saved state is frozen.
            if (!power_sat_q && (lam_inc == power_q)) begin
              saved_d = x_next;
              lam_d   = '0;
              if (power_q[SW-1]) power_sat_d = 1'b1;
              else               power_d     = power_q << 1;
            end else begin
              lam_d = lam_inc;
            end
            if (steps_inc == max_q) begin
              state_d  = DONE;
              status_d = ST_TIMEOUT;
              period_d = '0;
              done_d   = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pos_q       <= '{default: '0};
      neg_q       <= '{default: '0};
      x_q         <= '0;
      saved_q     <= '0;
      power_q     <= '0;
      power_sat_q <= 1'b0;
      lam_q       <= '0;
      steps_q     <= '0;
      max_q       <= '0;
      period_q    <= '0;
      status_q    <= ST_NONE;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      neg_q       <= neg_d;
      x_q         <= x_d;
      saved_q     <= saved_d;
      power_q     <= power_d;
      power_sat_q <= power_sat_d;
      lam_q       <= lam_d;
      steps_q     <= steps_d;
      max_q       <= max_d;
      period_q    <= period_d;
      status_q    <= status_d;
      done_q      <= done_d;
    end
  end

  assign bus.x_out  = x_q;
  assign bus.busy   = (state_q == RUN);
  assign bus.done   = done_q;
  assign bus.status = status_q;
  assign bus.period = period_q;
  assign bus.steps  = steps_q;

endmodule

// File: tb/tb_gene_net_attr.sv
// Scoreboard bench for gene_net_attr: each reported run is queued at start and
// matched against the DUT result when done pulses.
module tb_gene_net_attr;

  localparam int N  = 8;
  localparam int SW = 16;

  typedef struct packed {
    logic [1:0]    st;
    logic [SW-1:0] per;
    logic [SW-1:0] stp;
    logic [N-1:0]  x;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];

  gene_net_attr_if #(.N(N), .SW(SW)) bus ();

  gene_net_attr #(.N(N), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Result monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      check_val("done_single_cycle", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        $display("run done: status=%0d period=%0d steps=%0d x_out=%02h", bus.status, bus.period, bus.steps, bus.x_out);
        check_val("status", 32'(bus.status), 32'(e.st));
        check_val("period", 32'(bus.period), 32'(e.per));
        check_val("steps",  32'(bus.steps),  32'(e.stp));
        check_val("x_out",  32'(bus.x_out),  32'(e.x));
      end
    end
    prev_done = bus.done;
  end

  task automatic write_rule(input int gene, input bit term, input logic [N-1:0] pos, input logic [N-1:0] neg);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_gene = 3'(gene);
    bus.cfg_term = term;
    bus.cfg_pos  = pos;
    bus.cfg_neg  = neg;
    @(posedge clk);
    #1 bus.cfg_we = 1'b0;
  endtask

  task automatic do_start(input logic [N-1:0] x, input logic [SW-1:0] mx);
    @(negedge clk);
    bus.x_in      = x;
    bus.max_steps = mx;
    bus.start     = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check_val("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic push_exp(input logic [1:0] st, input int per, input int stp, input logic [N-1:0] x);
    exp_t e;
    e.st = st; e.per = SW'(per); e.stp = SW'(stp); e.x = x;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      check_val("run_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_x_out"},  32'(bus.x_out),  32'd0);
    check_val({tag, "_busy"},   32'(bus.busy),   32'd0);
    check_val({tag, "_done"},   32'(bus.done),   32'd0);
    check_val({tag, "_status"}, 32'(bus.status), 32'd0);
    check_val({tag, "_period"}, 32'(bus.period), 32'd0);
    check_val({tag, "_steps"},  32'(bus.steps),  32'd0);
  endtask

  task automatic load_rotate();
    for (int i = 0; i < N; i++) write_rule(i, 1'b0, N'(1) << ((i + N - 1) % N), '0);
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_gene = '0; bus.cfg_term = 1'b0;
    bus.cfg_pos = '0; bus.cfg_neg = '0; bus.start = 1'b0;
    bus.x_in = '0; bus.max_steps = '0; bus.abort = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // All rules zero: FF -> 00 -> 00, a fixed point.
    push_exp(2'b01, 1, 2, 8'h00);
    do_start(8'hFF, 16'd100);
    wait_empty(50);

    // Rotate-left network; a start mid-run must not disturb it.
    load_rotate();
    push_exp(2'b10, 8, 15, 8'h80);
    do_start(8'h01, 16'd100);
    repeat (2) @(negedge clk);
    bus.x_in = 8'hFF; bus.max_steps = 16'd1; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_empty(60);

    // Timeout before the cycle is found, then results must hold in DONE.
    push_exp(2'b11, 0, 5, 8'h20);
    do_start(8'h01, 16'd5);
    wait_empty(30);
    repeat (3) @(negedge clk);
    check_val("hold_status", 32'(bus.status), 32'd3);
    check_val("hold_steps",  32'(bus.steps),  32'd5);
    check_val("hold_busy",   32'(bus.busy),   32'd0);

    // max_steps=0: immediate timeout, no update applied.
    push_exp(2'b11, 0, 0, 8'h5A);
    do_start(8'h5A, 16'd0);
    wait_empty(10);

    // Abort mid-run with an ignored rule write issued while busy.
    do_start(8'h01, 16'd100);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_gene = 3'd0; bus.cfg_term = 1'b1;
    bus.cfg_pos = 8'h01; bus.cfg_neg = 8'h00;
    @(posedge clk);
    #1 bus.cfg_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    check_val("abort_busy",   32'(bus.busy),   32'd0);
    check_val("abort_status", 32'(bus.status), 32'd0);
    check_val("abort_x_out",  32'(bus.x_out),  32'h04);
    repeat (3) @(negedge clk);
    check_val("abort_no_done", 32'(bus.done), 32'd0);
    push_exp(2'b10, 8, 15, 8'h80);
    do_start(8'h01, 16'd100);
    wait_empty(60);

    // Reset mid-run abandons the run and clears the rules.
    do_start(8'h01, 16'd100);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    rst_n = 1'b1;
    push_exp(2'b01, 1, 2, 8'h00);
    do_start(8'hFF, 16'd100);
    wait_empty(50);

    // Gene0 = NOT gene0, others constant zero: 01 -> 00 -> 01 -> 00.
    write_rule(0, 1'b0, 8'h00, 8'h01);
    push_exp(2'b10, 2, 3, 8'h00);
    do_start(8'h01, 16'd100);
    wait_empty(50);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
